// File: rtl/row_data_distributor_if.sv
// -----------------------------------------------------------------------------
// row_data_distributor_if
// Groups the serial-input handshake, the row-FIFO flags/strobes and the packed
// output bus of row_data_distributor.
//
// Handshake: a word on i_data transfers on a rising clock edge where both
// i_valid and o_ready are high. When o_ready is low the source must hold
// i_data/i_valid; nothing is captured.
//
// Signals (ROW = number of array rows):
//   i_data         [8:0]        serial input word
//   i_valid                     i_data valid
//   o_ready                     distributor accepts i_data this cycle
//   i_fifo_full    [ROW-1:0]    per-row FIFO full flags, bit k = row k
//   o_data         [9*ROW-1:0]  packed group, row k at bits [9k+8:9k]
//   o_write_enable [ROW-1:0]    per-row FIFO write strobe
//   o_busy                      group in progress or commit pending
//   dbg_state                   FSM state (0 = FILL, 1 = COMMIT)
// Modports: master = source/FIFO side, slave = distributor.
// -----------------------------------------------------------------------------
interface row_data_distributor_if #(
  parameter int ROW = 9
);
  logic [8:0]       i_data;
  logic             i_valid;
  logic             o_ready;
  logic [ROW-1:0]   i_fifo_full;
  logic [9*ROW-1:0] o_data;
  logic [ROW-1:0]   o_write_enable;
  logic             o_busy;
  logic             dbg_state;

  modport master (
    output i_data, i_valid, i_fifo_full,
    input  o_ready, o_data, o_write_enable, o_busy, dbg_state
  );

  modport slave (
    input  i_data, i_valid, i_fifo_full,
    output o_ready, o_data, o_write_enable, o_busy, dbg_state
  );
endinterface

// File: rtl/row_data_distributor.sv
// -----------------------------------------------------------------------------
// row_data_distributor
// Write-side counterpart of the row-FIFO read controller. Gathers ROW serial
// 9-bit words into a group buffer (word n -> row n), then writes the whole
// group into all ROW row FIFOs in one cycle, only when no FIFO is full.
// Every row FIFO therefore receives exactly one word per group.
//
// Ports:
//   i_clk    single clock, all state on the rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      row_data_distributor_if.slave (data/valid/ready, fifo flags,
//            packed output, write strobes, busy, debug state)
// -----------------------------------------------------------------------------
module row_data_distributor #(
  parameter int ROW = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  row_data_distributor_if.slave bus
);

  localparam int SW = $clog2(ROW);
  localparam logic [SW-1:0] LAST_SLOT = SW'(ROW - 1);

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_COMMIT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          slot_q, slot_d;
  logic [ROW-1:0][8:0]    buf_q, buf_d;
  logic [9*ROW-1:0]       data_q, data_d;
  logic [ROW-1:0]         we_q, we_d;

  logic ready;
  logic accept;
  logic fifo_clear;
  logic commit_go;

  assign accept     = bus.i_valid && ready;
  assign fifo_clear = (bus.i_fifo_full == '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (accept && (slot_q == LAST_SLOT)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // Wait indefinitely for every FIFO to have room; never write a subset.
        if (fifo_clear) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ready     = 1'b0;
    commit_go = 1'b0;
    case (state_q)
      ST_FILL:   ready     = 1'b1;
      ST_COMMIT: commit_go = fifo_clear;
      default: begin
        ready     = 1'b0;
        commit_go = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next state: slot counter, group buffer, output register, strobe
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_d = slot_q;
    buf_d  = buf_q;
    data_d = data_q;
    we_d   = '0;
    if (accept) begin
      buf_d[slot_q] = bus.i_data;
      slot_d        = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
    end
    if (commit_go) begin
      data_d = buf_q;
      we_d   = '1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_q <= '0;
      buf_q  <= '0;
      data_q <= '0;
      we_q   <= '0;
    end else begin
      slot_q <= slot_d;
      buf_q  <= buf_d;
      data_q <= data_d;
      we_q   <= we_d;
    end
  end

  assign bus.o_ready        = ready;
  assign bus.o_data         = data_q;
  assign bus.o_write_enable = we_q;
  assign bus.o_busy         = (state_q != ST_FILL) || (slot_q != '0);
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_row_data_distributor.sv
// -----------------------------------------------------------------------------
// tb_row_data_distributor
// Reference model: every ROW words the source hands over form one group
// (word n of the group belongs to row n). The driver pushes each completed
// group into exp_q; a monitor pops it whenever a write strobe appears.
// -----------------------------------------------------------------------------
module tb_row_data_distributor;

  localparam int ROW = 9;
  localparam int W   = 9 * ROW;

  logic clk;
  logic rst_n;
  int   cyc;

  row_data_distributor_if #(.ROW(ROW)) bus ();

  row_data_distributor #(.ROW(ROW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0]   exp_q[$];
  logic [8:0]     cur_words[$];
  int             strobe_cyc_q[$];
  int             compared   = 0;
  int             mismatched = 0;
  bit             rand_full_en = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a group is simply the next ROW words in order.
  task automatic model_accept(input logic [8:0] w);
    logic [W-1:0] g;
    cur_words.push_back(w);
    if (cur_words.size() == ROW) begin
      g = '0;
      for (int k = 0; k < ROW; k++) g[9*k +: 9] = cur_words[k];
      exp_q.push_back(g);
      cur_words.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    logic [31:0] r;
    @(posedge clk);
    #1;
    if (rand_full_en) begin
      r = $urandom;
      bus.i_fifo_full = ($urandom_range(0, 2) == 0) ? r[ROW-1:0] : '0;
    end
  endtask

  task automatic send_word(input logic [8:0] w);
    bit done;
    int n;
    done = 0;
    n    = 0;
    bus.i_data  = w;
    bus.i_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = bus.o_ready;
      tick();
      if (!done) begin
        n++;
        if (n > 200) begin
          check("send_timeout", 1'b0, 1'b1);
          done = 1;
          n    = -1;
        end
      end
    end
    bus.i_valid = 1'b0;
    if (n >= 0) model_accept(w);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cur_words.delete();
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_complete", W'(exp_q.size()), '0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares each write strobe against the oldest expected group
  // ---------------------------------------------------------------------------
  logic           prev_we;
  logic [W-1:0]   last_data;
  logic [ROW-1:0] prev_full;
  logic [W-1:0]   exp_g;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_we   = 1'b0;
      last_data = '0;
      prev_full = '0;
    end else begin
      if (bus.o_write_enable != '0) begin
        check("strobe_all_rows", W'(bus.o_write_enable), W'({ROW{1'b1}}));
        check("strobe_single_cycle", W'(prev_we), '0);
        check("strobe_only_when_not_full", W'(prev_full), '0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", W'(bus.o_write_enable), '0);
        end else begin
          exp_g = exp_q.pop_front();
          check("group_data", bus.o_data, exp_g);
        end
        strobe_cyc_q.push_back(cyc);
      end else if (bus.o_data != last_data) begin
        check("data_stable", bus.o_data, last_data);
      end
      prev_we   = (bus.o_write_enable != '0);
      last_data = bus.o_data;
      prev_full = bus.i_fifo_full;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [W-1:0] saved_data;
  int           s0;

  initial begin
    cyc             = 0;
    rst_n           = 1'b0;
    bus.i_data      = '0;
    bus.i_valid     = 1'b0;
    bus.i_fifo_full = '0;
    #2;
    check("reset_ready", W'(bus.o_ready), W'(1'b1));
    check("reset_we", W'(bus.o_write_enable), '0);
    check("reset_data", bus.o_data, '0);
    check("reset_busy", W'(bus.o_busy), '0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Continuous group 1..9, no full flags.
    for (int w = 1; w <= ROW; w++) send_word(9'(w));
    @(negedge clk);
    check("t2_ready_low", W'(bus.o_ready), '0);
    check("t2_busy_commit", W'(bus.o_busy), W'(1'b1));
    check("t2_no_early_strobe", W'(bus.o_write_enable), '0);
    tick();
    @(negedge clk);
    check("t2_ready_back", W'(bus.o_ready), W'(1'b1));
    check("t2_strobe", W'(bus.o_write_enable), W'({ROW{1'b1}}));
    check("t2_row0", W'(bus.o_data[8:0]), W'(9'h001));
    check("t2_row8", W'(bus.o_data[80:72]), W'(9'h009));
    saved_data = bus.o_data;
    tick();

    // Same stream, one FIFO full for 5 cycles at commit.
    for (int w = 1; w <= ROW; w++) send_word(9'(w));
    bus.i_fifo_full = 9'b000010000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_blocked_we", W'(bus.o_write_enable), '0);
      check("t3_blocked_ready", W'(bus.o_ready), '0);
      tick();
    end
    bus.i_fifo_full = '0;
    @(negedge clk);
    check("t3_commit_cycle_we", W'(bus.o_write_enable), '0);
    tick();
    @(negedge clk);
    check("t3_strobe", W'(bus.o_write_enable), W'({ROW{1'b1}}));
    check("t3_data", bus.o_data, saved_data);
    tick();

    // Gapped input: one word every 3 cycles.
    for (int w = 1; w <= ROW; w++) begin
      send_word(9'(w));
      repeat (2) tick();
    end
    drain();

    // Two groups back-to-back: strobes 10 cycles apart.
    s0 = strobe_cyc_q.size();
    for (int w = 1; w <= 2 * ROW; w++) send_word(9'(w));
    drain();
    tick();
    check("t5_strobe_count", W'(strobe_cyc_q.size() - s0), W'(2));
    if (strobe_cyc_q.size() - s0 == 2)
      check("t5_strobe_spacing", W'(strobe_cyc_q[s0+1] - strobe_cyc_q[s0]), W'(ROW + 1));

    // Reset while the write strobe is high: outputs clear asynchronously.
    for (int w = 0; w < ROW; w++) send_word(9'(9'h0A0 + w));
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("t1_async_we", W'(bus.o_write_enable), '0);
    check("t1_async_data", bus.o_data, '0);
    do_reset();
    @(negedge clk);
    check("t1_ready_after", W'(bus.o_ready), W'(1'b1));
    check("t1_busy_after", W'(bus.o_busy), '0);
    tick();

    // Reset after a partial group; only the new group is written.
    for (int w = 0; w < 4; w++) send_word(9'(9'h1F0 + w));
    do_reset();
    for (int w = 0; w < ROW; w++) send_word(9'(9'h150 + 3 * w));
    drain();

    // Randomized words, gaps and FIFO-full patterns.
    rand_full_en = 1;
    for (int i = 0; i < 6 * ROW; i++) begin
      send_word(9'($urandom_range(0, 511)));
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_full_en    = 0;
    bus.i_fifo_full = '0;
    drain();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
